// File: rtl/osc_bank_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// osc_pkg : default oscillator bank sizing and note-index addressing enum
// Revision: 1.0
// ---------------------------------------------------------------------------
package osc_pkg;

  localparam int OSC_NUM_CH = 12;
  localparam int OSC_CNT_W  = 18;

  typedef enum logic [3:0] {
    NOTE_C  = 4'd0,
    NOTE_CS = 4'd1,
    NOTE_D  = 4'd2,
    NOTE_DS = 4'd3,
    NOTE_E  = 4'd4,
    NOTE_F  = 4'd5,
    NOTE_FS = 4'd6,
    NOTE_G  = 4'd7,
    NOTE_GS = 4'd8,
    NOTE_A  = 4'd9,
    NOTE_AS = 4'd10,
    NOTE_B  = 4'd11
  } note_e;

endpackage : osc_pkg
`default_nettype wire

// File: rtl/osc_bank_chan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// osc_chan : one divider channel with wrap-aligned shadow limit loading
// Revision: 1.0  (square output present only with OSC_BANK_SQ_EN)
// ---------------------------------------------------------------------------
module osc_chan
  import osc_pkg::*;
#(
  parameter int CNT_W = OSC_CNT_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sq
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] plim_q, plim_d;
  logic             pend_q, pend_d;
  logic             wrap_q, wrap_d;
  logic             at_lim;
  logic [CNT_W-1:0] load_lim;

  assign at_lim   = (cnt_q >= lim_q);
  // Limit that takes effect at a load point: a same-cycle write beats the shadow.
  assign load_lim = wr_en ? wr_data : (pend_q ? plim_q : lim_q);

  always_comb begin
    cnt_d  = cnt_q;
    lim_d  = lim_q;
    plim_d = plim_q;
    pend_d = pend_q;
    wrap_d = 1'b0;
    if (sync) begin
      cnt_d  = '0;
      pend_d = 1'b0;
      lim_d  = load_lim;
    end else if (!en) begin
      pend_d = 1'b0;
      lim_d  = load_lim;
    end else if (at_lim) begin
      cnt_d  = '0;
      wrap_d = 1'b1;
      pend_d = 1'b0;
      lim_d  = load_lim;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (wr_en) begin
        plim_d = wr_data;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      lim_q  <= '0;
      plim_q <= '0;
      pend_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lim_q  <= lim_d;
      plim_q <= plim_d;
      pend_q <= pend_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;

`ifdef OSC_BANK_SQ_EN
  logic sq_q, sq_d;

  always_comb begin
    sq_d = sq_q;
    if (sync) begin
      sq_d = 1'b0;
    end else if (en && at_lim) begin
      sq_d = ~sq_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq = sq_q;
`else
  assign sq = 1'b0;
`endif

endmodule : osc_chan
`default_nettype wire

// File: rtl/osc_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// osc_bank : NUM_CH free-running divider channels with runtime limit writes
// Revision: 1.0  (square outputs enabled by OSC_BANK_SQ_EN)
// ---------------------------------------------------------------------------
module osc_bank
  import osc_pkg::*;
#(
  parameter  int NUM_CH = OSC_NUM_CH,
  parameter  int CNT_W  = OSC_CNT_W,
  localparam int ADDR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    sync,
  input  logic                    lim_wr_en,
  input  logic [ADDR_W-1:0]       lim_wr_addr,
  input  logic [CNT_W-1:0]        lim_wr_data,
  output logic [NUM_CH*CNT_W-1:0] cnt_out,
  output logic [NUM_CH-1:0]       wrap,
  output logic [NUM_CH-1:0]       sq_out
);

  // Out-of-range addresses match no channel, so such writes fall away here.
  logic [NUM_CH-1:0] wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = lim_wr_en && (lim_wr_addr == ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    osc_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk     (clk),
      .n_rst   (n_rst),
      .en      (ch_en[g]),
      .sync    (sync),
      .wr_en   (wr_sel[g]),
      .wr_data (lim_wr_data),
      .cnt     (cnt_out[g*CNT_W +: CNT_W]),
      .wrap    (wrap[g]),
      .sq      (sq_out[g])
    );
  end

endmodule : osc_bank
`default_nettype wire

// File: tb/tb_osc_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_osc_bank : directed self-checking bench for osc_bank
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_osc_bank;

  localparam int NUM_CH = 12;
  localparam int CNT_W  = 18;
  localparam int ADDR_W = 4;
`ifdef OSC_BANK_SQ_EN
  localparam bit SQ_ON = 1'b1;
`else
  localparam bit SQ_ON = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    n_rst = 1'b0;
  logic [NUM_CH-1:0]       ch_en = '0;
  logic                    sync = 1'b0;
  logic                    lim_wr_en = 1'b0;
  logic [ADDR_W-1:0]       lim_wr_addr = '0;
  logic [CNT_W-1:0]        lim_wr_data = '0;
  logic [NUM_CH*CNT_W-1:0] cnt_out;
  logic [NUM_CH-1:0]       wrap;
  logic [NUM_CH-1:0]       sq_out;

  int n_checks = 0;
  int n_pass   = 0;

  osc_bank #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .ch_en       (ch_en),
    .sync        (sync),
    .lim_wr_en   (lim_wr_en),
    .lim_wr_addr (lim_wr_addr),
    .lim_wr_data (lim_wr_data),
    .cnt_out     (cnt_out),
    .wrap        (wrap),
    .sq_out      (sq_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one write for a single cycle.
  task automatic wr_tick(input int ch, input int data);
    lim_wr_en   = 1'b1;
    lim_wr_addr = ADDR_W'(ch);
    lim_wr_data = CNT_W'(data);
    tick();
    lim_wr_en   = 1'b0;
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return cnt_out[ch*CNT_W +: CNT_W];
  endfunction

  function automatic logic sqv(input logic b);
    return b & SQ_ON;
  endfunction

  initial begin
    // Reset hold
    repeat (3) tick();
    check("rst_cnt", cnt_out, '0);
    check("rst_wrap", wrap, '0);
    check("rst_sq", sq_out, '0);
    n_rst = 1'b1;
    tick();
    check("post_rst_cnt", cnt_out, '0);
    check("post_rst_wrap", wrap, '0);

    // Reset limit is 0: an enabled channel wraps every cycle
    ch_en[3] = 1'b1;
    tick();
    check("lim0_wrap3", wrap[3], 1'b1);
    check("lim0_cnt3", cnt_of(3), 0);
    check("lim0_sq3", sq_out[3], sqv(1'b1));
    ch_en[3] = 1'b0;
    tick();
    check("dis_wrap", wrap, '0);
    check("dis_sq3_hold", sq_out[3], sqv(1'b1));

    // Channel 0 limit 3 -> period 4, square period 8
    wr_tick(0, 3);
    ch_en[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("ch0_cnt_%0d", k), cnt_of(0), k % 4);
      check($sformatf("ch0_wrap_%0d", k), wrap[0], (k % 4) == 0);
      check($sformatf("ch0_sq_%0d", k), sq_out[0], sqv(((k / 4) % 2) == 1));
    end
    ch_en[0] = 1'b0;

    // Channel 2: new limit written mid-period waits for the wrap
    wr_tick(2, 3);
    ch_en[2] = 1'b1;
    tick();
    check("ch2_cnt1", cnt_of(2), 1);
    wr_tick(2, 9);
    check("ch2_cnt2", cnt_of(2), 2);
    tick();
    check("ch2_cnt3", cnt_of(2), 3);
    tick();
    check("ch2_wrap_old", {wrap[2], cnt_of(2)}, {1'b1, 18'd0});
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("ch2_new_%0d", k), {wrap[2], cnt_of(2)}, {1'b0, CNT_W'(k)});
    end
    tick();
    check("ch2_wrap_new", {wrap[2], cnt_of(2)}, {1'b1, 18'd0});
    tick();
    ch_en[2] = 1'b0;

    // Channel 5: pending limit taken at sync
    wr_tick(5, 2);
    ch_en[5] = 1'b1;
    tick();
    check("ch5_cnt1", cnt_of(5), 1);
    wr_tick(5, 6);
    check("ch5_cnt2", cnt_of(5), 2);
    check("pre_sync_ch2", cnt_of(2), 1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_cnt", cnt_out, '0);
    check("sync_sq", sq_out, '0);
    check("sync_wrap", wrap, '0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("ch5_pend_%0d", k), {wrap[5], cnt_of(5)}, {1'b0, CNT_W'(k)});
    end
    tick();
    check("ch5_wrap", {wrap[5], cnt_of(5)}, {1'b1, 18'd0});
    ch_en[5] = 1'b0;

    // Channel 4: pause at 6 then resume
    wr_tick(4, 9);
    ch_en[4] = 1'b1;
    repeat (6) tick();
    check("ch4_cnt6", cnt_of(4), 6);
    ch_en[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("ch4_hold_%0d", k), {wrap[4], cnt_of(4)}, {1'b0, 18'd6});
    end
    ch_en[4] = 1'b1;
    tick();
    check("ch4_resume7", cnt_of(4), 7);
    tick();
    tick();
    check("ch4_cnt9", cnt_of(4), 9);
    tick();
    check("ch4_wrap", {wrap[4], cnt_of(4)}, {1'b1, 18'd0});
    ch_en[4] = 1'b0;

    // Out-of-range write address changes nothing
    wr_tick(15, 1);
    ch_en = 12'b0000_0001_1000;
    tick();
    check("oor_ch3_a", {wrap[3], cnt_of(3)}, {1'b1, 18'd0});
    check("oor_ch4_a", {wrap[4], cnt_of(4)}, {1'b0, 18'd1});
    tick();
    check("oor_ch3_b", {wrap[3], cnt_of(3)}, {1'b1, 18'd0});
    check("oor_ch4_b", {wrap[4], cnt_of(4)}, {1'b0, 18'd2});
    ch_en = '0;

    // Channel 1: last write (0) wins, wrap held high
    wr_tick(1, 5);
    wr_tick(1, 0);
    ch_en[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("ch1_wrap_%0d", k), {wrap[1], cnt_of(1)}, {1'b1, 18'd0});
      check($sformatf("ch1_sq_%0d", k), sq_out[1], sqv((k % 2) == 1));
    end

    // Asynchronous reset mid-operation
    ch_en[0] = 1'b1;
    tick();
    check("pre_rst_ch0", cnt_of(0), 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_cnt", cnt_out, '0);
    check("async_rst_wrap", wrap, '0);
    check("async_rst_sq", sq_out, '0);
    n_rst = 1'b1;
    tick();
    check("post_async_wrap", wrap, 12'b0000_0000_0011);
    check("post_async_cnt", cnt_out, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_osc_bank
`default_nettype wire
